serial_subtractor: RTL

Multi-cycle, digit-serial two's-complement subtractor. It computes d = a − b − bin, CHUNK bits per clock, LSB chunk first, and carries the borrow between chunks in a register. It sits beside the combinational ripple adders in the datapath and is used where a full-width single-cycle borrow chain would not close timing. A start/busy/done handshake frames each operation.

---
 rtl/serial_subtractor_if.sv | 29 ++
 rtl/serial_subtractor.sv | 117 +++++++++++
 2 files changed

// File: rtl/serial_subtractor_if.sv
// Operation bus of the digit-serial subtractor.
// Handshake: start is a request sampled only while the block is idle. The
// accepting edge latches a, b and bin. busy is high while chunks are being
// processed. done is a one-cycle pulse that marks d, bout and ovf as fresh.
// A start seen while busy or done is dropped, never queued.
interface serial_subtractor_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             ovf;
  logic [1:0]       dbg_state;  // FSM state, for checkers and waveforms

  modport master (
    output start, a, b, bin,
    input  busy, done, d, bout, ovf, dbg_state
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, d, bout, ovf, dbg_state
  );
endinterface

// File: rtl/serial_subtractor.sv
// Digit-serial two's-complement subtractor: d = a - b - bin, CHUNK bits per
// clock, LSB chunk first, with the borrow carried between chunks in a
// register. Used where a full-width single-cycle borrow chain is too slow.
module serial_subtractor #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic                clk,
  input logic                rst_n,
  serial_subtractor_if.slave bus
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] work;
  logic             borrow;
  logic [CW-1:0]    cnt;

  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] d_r;
  logic             bout_r;
  logic             ovf_r;

  logic [CHUNK-1:0] a_k;
  logic [CHUNK-1:0] b_k;
  logic [CHUNK:0]   sub_k;
  logic [CHUNK-1:0] diff_k;
  logic             borrow_nx;
  logic             msb_bin;
  logic             last;
  logic [WIDTH-1:0] next_work;

  // Current chunk arithmetic and the working register with it merged in.
  // The borrow into the top bit is recovered from the top bit's own sum
  // (diff ^ a ^ b), which is only meaningful on the MSB chunk.
  always_comb begin
    a_k       = op_a[int'(cnt) * CHUNK +: CHUNK];
    b_k       = op_b[int'(cnt) * CHUNK +: CHUNK];
    sub_k     = {1'b0, a_k} - {1'b0, b_k} - {{CHUNK{1'b0}}, borrow};
    diff_k    = sub_k[CHUNK-1:0];
    borrow_nx = sub_k[CHUNK];
    msb_bin   = diff_k[CHUNK-1] ^ a_k[CHUNK-1] ^ b_k[CHUNK-1];
    last      = (cnt == CW'(N - 1));
    next_work = work;
    next_work[int'(cnt) * CHUNK +: CHUNK] = diff_k;
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_a   <= '0;
      op_b   <= '0;
      work   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      d_r    <= '0;
      bout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_a   <= bus.a;
            op_b   <= bus.b;
            borrow <= bus.bin;
            work   <= '0;
            cnt    <= '0;
            busy_r <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          work   <= next_work;
          borrow <= borrow_nx;
          if (last) begin
            d_r    <= next_work;
            bout_r <= borrow_nx;
            ovf_r  <= msb_bin ^ borrow_nx;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            cnt    <= '0;
            state  <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          done_r <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.d         = d_r;
  assign bus.bout      = bout_r;
  assign bus.ovf       = ovf_r;
  assign bus.dbg_state = state;
endmodule
